// File: rtl/fetch_unit_if.sv
// Fetch unit bus bundle: instruction memory request/response and decode-side queue view.
// master = fetch unit, slave = memory/decode environment.
interface fetch_unit_if #(
  parameter int PC_SIZE     = 32,
  parameter int INSTR_SIZE  = 32,
  parameter int FETCH_WIDTH = 2,
  parameter int QUEUE_DEPTH = 8
);
  localparam int CNT_W = $clog2(QUEUE_DEPTH) + 1;

  logic                                   imem_req_valid_o;
  logic                                   imem_req_ready_i;
  logic [PC_SIZE-1:0]                     imem_req_addr_o;
  logic                                   imem_rsp_valid_i;
  logic [FETCH_WIDTH-1:0][INSTR_SIZE-1:0] imem_rsp_data_i;
  logic                                   redirect_i;
  logic [PC_SIZE-1:0]                     redirect_pc_i;
  logic [FETCH_WIDTH-1:0]                 dec_valid_o;
  logic [FETCH_WIDTH-1:0][INSTR_SIZE-1:0] dec_instr_o;
  logic [FETCH_WIDTH-1:0][PC_SIZE-1:0]    dec_pc_o;
  logic                                   dec_ready_i;
  logic [CNT_W-1:0]                       count_o;

  modport master (
    output imem_req_valid_o, imem_req_addr_o, dec_valid_o, dec_instr_o, dec_pc_o, count_o,
    input  imem_req_ready_i, imem_rsp_valid_i, imem_rsp_data_i, redirect_i, redirect_pc_i,
           dec_ready_i
  );

  modport slave (
    input  imem_req_valid_o, imem_req_addr_o, dec_valid_o, dec_instr_o, dec_pc_o, count_o,
    output imem_req_ready_i, imem_rsp_valid_i, imem_rsp_data_i, redirect_i, redirect_pc_i,
           dec_ready_i
  );
endinterface

// File: rtl/fetch_unit.sv
// Line-based instruction fetch with one outstanding request and a circular fetch queue.
// Define FETCH_PERF_EN to add the perf_lines_o / perf_stall_o counters.

// Maps queue write position SLOT to its source slot in the response line.
module fetch_slot #(
  parameter int PC_SIZE     = 32,
  parameter int INSTR_SIZE  = 32,
  parameter int FETCH_WIDTH = 2,
  parameter int OFF_W       = 1,
  parameter int SLOT        = 0
) (
  input  logic [OFF_W-1:0]                     off,
  input  logic [PC_SIZE-1:0]                   line,
  input  logic [FETCH_WIDTH-1:0][INSTR_SIZE-1:0] data,
  output logic                                 keep,
  output logic [PC_SIZE-1:0]                   pc,
  output logic [INSTR_SIZE-1:0]                instr
);
  logic [OFF_W:0]   src;
  logic [OFF_W-1:0] idx;

  assign src   = {1'b0, off} + (OFF_W+1)'(SLOT);
  assign idx   = src[OFF_W-1:0];
  assign keep  = src < (OFF_W+1)'(FETCH_WIDTH);
  assign pc    = line + (PC_SIZE'(src) << 2);
  assign instr = keep ? data[idx] : '0;
endmodule

module fetch_unit #(
  parameter int                 PC_SIZE     = 32,
  parameter int                 INSTR_SIZE  = 32,
  parameter int                 FETCH_WIDTH = 2,
  parameter int                 QUEUE_DEPTH = 8,
  parameter logic [PC_SIZE-1:0] RESET_PC    = '0
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  fetch_unit_if.master bus
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]  perf_lines_o,
  output logic [31:0]  perf_stall_o
`endif
);
  localparam int LINE_B = FETCH_WIDTH * 4;
  localparam int PTR_W  = $clog2(QUEUE_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int OFF_W  = (FETCH_WIDTH > 1) ? $clog2(FETCH_WIDTH) : 1;

  typedef struct packed {
    logic [PC_SIZE-1:0]    pc;
    logic [INSTR_SIZE-1:0] instr;
  } entry_t;

  entry_t           mem_q [QUEUE_DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, wr_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic [PC_SIZE-1:0] pc_q, line_pc, line_q;
  logic [OFF_W-1:0] pc_off, off_q;
  logic             outst_q, discard_q;

  logic             has_room, req_valid, req_fire, rsp_take, push_en;
  logic [CNT_W-1:0] avail, push_n, pop_n;

  logic [FETCH_WIDTH-1:0]                 wkeep;
  logic [FETCH_WIDTH-1:0][PC_SIZE-1:0]    wpc;
  logic [FETCH_WIDTH-1:0][INSTR_SIZE-1:0] winstr;
  logic [FETCH_WIDTH-1:0]                 rvalid;
  logic [FETCH_WIDTH-1:0][PC_SIZE-1:0]    rpc;
  logic [FETCH_WIDTH-1:0][INSTR_SIZE-1:0] rinstr;

  assign line_pc  = pc_q & ~PC_SIZE'(LINE_B - 1);
  assign pc_off   = OFF_W'((pc_q >> 2) & PC_SIZE'(FETCH_WIDTH - 1));
  assign has_room = (CNT_W'(QUEUE_DEPTH) - count_q) >= CNT_W'(FETCH_WIDTH);

  // rst_ni gates valid so nothing is requested while reset is held.
  assign req_valid = rst_ni & ~outst_q & ~bus.redirect_i & has_room;
  assign req_fire  = req_valid & bus.imem_req_ready_i;
  assign rsp_take  = bus.imem_rsp_valid_i & outst_q;
  assign push_en   = rsp_take & ~discard_q & ~bus.redirect_i;

  assign avail  = (count_q < CNT_W'(FETCH_WIDTH)) ? count_q : CNT_W'(FETCH_WIDTH);
  assign pop_n  = (bus.dec_ready_i && !bus.redirect_i) ? avail : '0;
  assign push_n = push_en ? (CNT_W'(FETCH_WIDTH) - CNT_W'(off_q)) : '0;

  for (genvar j = 0; j < FETCH_WIDTH; j++) begin : g_slot
    fetch_slot #(
      .PC_SIZE(PC_SIZE), .INSTR_SIZE(INSTR_SIZE), .FETCH_WIDTH(FETCH_WIDTH),
      .OFF_W(OFF_W), .SLOT(j)
    ) u_slot (
      .off(off_q), .line(line_q), .data(bus.imem_rsp_data_i),
      .keep(wkeep[j]), .pc(wpc[j]), .instr(winstr[j])
    );
  end

  always_comb begin
    rvalid = '0;
    rpc    = '0;
    rinstr = '0;
    for (int k = 0; k < FETCH_WIDTH; k++) begin
      rvalid[k] = count_q > CNT_W'(k);
      rpc[k]    = mem_q[rd_ptr_q + PTR_W'(k)].pc;
      rinstr[k] = mem_q[rd_ptr_q + PTR_W'(k)].instr;
    end
  end

  assign bus.imem_req_valid_o = req_valid;
  assign bus.imem_req_addr_o  = line_pc;
  assign bus.dec_valid_o      = rvalid;
  assign bus.dec_pc_o         = rpc;
  assign bus.dec_instr_o      = rinstr;
  assign bus.count_o          = count_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pc_q      <= RESET_PC;
      line_q    <= '0;
      off_q     <= '0;
      outst_q   <= 1'b0;
      discard_q <= 1'b0;
      count_q   <= '0;
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
    end else begin
      if (req_fire) begin
        outst_q <= 1'b1;
        line_q  <= line_pc;
        off_q   <= pc_off;
      end else if (rsp_take) begin
        outst_q   <= 1'b0;
        discard_q <= 1'b0;
      end
      if (bus.redirect_i) begin
        // An in-flight request keeps the outstanding flag so its late response is matched and dropped.
        pc_q      <= bus.redirect_pc_i;
        count_q   <= '0;
        rd_ptr_q  <= '0;
        wr_ptr_q  <= '0;
        discard_q <= (outst_q & ~rsp_take) | req_fire;
      end else begin
        if (req_fire) pc_q <= line_pc + PC_SIZE'(LINE_B);
        count_q  <= count_q + push_n - pop_n;
        rd_ptr_q <= rd_ptr_q + PTR_W'(pop_n);
        wr_ptr_q <= wr_ptr_q + PTR_W'(push_n);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    for (int j = 0; j < FETCH_WIDTH; j++)
      if (push_en && wkeep[j]) mem_q[wr_ptr_q + PTR_W'(j)] <= {wpc[j], winstr[j]};
  end

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      perf_lines_o <= '0;
      perf_stall_o <= '0;
    end else begin
      if (push_en && perf_lines_o != '1) perf_lines_o <= perf_lines_o + 32'd1;
      if (count_q == '0 && !bus.redirect_i && perf_stall_o != '1) perf_stall_o <= perf_stall_o + 32'd1;
    end
  end
`endif
endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The block SHALL provide these parameters:
- PC_SIZE, default 32: program counter width.
- INSTR_SIZE, default 32: instruction width.
- FETCH_WIDTH, default 2: instructions per fetch line; power of 2, at least 1.
- QUEUE_DEPTH, default 8: fetch queue entries; power of 2, at least 2*FETCH_WIDTH.
- RESET_PC, default 0: first fetch address after reset.
REQ-002 The block SHALL provide these ports (name, direction, width, meaning):
- clk_i  in  1  single clock, rising edge.
- rst_ni  in  1  asynchronous active-low reset.
- imem_req_valid_o  out  1  fetch request valid.
- imem_req_ready_i  in  1  memory accepts the request.
- imem_req_addr_o  out  PC_SIZE  line address, aligned to FETCH_WIDTH*4.
- imem_rsp_valid_i  in  1  response line valid.
- imem_rsp_data_i  in  FETCH_WIDTH*INSTR_SIZE  line data; slot k = bits [k*INSTR_SIZE +: INSTR_SIZE].
- redirect_i  in  1  flush and restart.
- redirect_pc_i  in  PC_SIZE  restart PC, 4-byte aligned.
- dec_valid_o  out  FETCH_WIDTH  per-slot valid, thermometer from slot 0.
- dec_instr_o  out  FETCH_WIDTH*INSTR_SIZE  oldest queued instructions; slot 0 is oldest.
- dec_pc_o  out  FETCH_WIDTH*PC_SIZE  PC of each slot.
- dec_ready_i  in  1  decode consumes all valid slots.
- count_o  out  clog2(QUEUE_DEPTH)+1  queue occupancy.

Function
REQ-003 At most one memory request SHALL be outstanding; the request handshake completes when imem_req_valid_o and imem_req_ready_i are both high.
REQ-004 imem_req_valid_o SHALL be high only when: no request is outstanding, redirect_i is low, and free entries (QUEUE_DEPTH - count_o) are at least FETCH_WIDTH.
REQ-005 imem_req_addr_o SHALL equal the fetch PC with its low log2(FETCH_WIDTH*4) bits cleared; it SHALL remain stable while valid is high and ready is low.
REQ-006 On each request handshake, the fetch PC SHALL advance to the aligned address plus FETCH_WIDTH*4, wrapping modulo 2^PC_SIZE.
REQ-007 Responses SHALL arrive no earlier than the cycle after the request handshake; a response SHALL clear the outstanding flag.
REQ-008 On a response, slots whose address is below the request's fetch PC offset SHALL be dropped; the remaining slots SHALL be pushed in slot order, each tagged with its PC.
REQ-009 When dec_ready_i is high, all entries indicated by dec_valid_o (popcount) SHALL be popped in that cycle; when dec_ready_i is low, nothing is popped.
REQ-010 dec_valid_o[k] SHALL be high exactly when count_o > k, for each k < FETCH_WIDTH.
REQ-011 A push and a pop in the same cycle SHALL both occur; count_o SHALL update to count + pushed - popped.
REQ-012 The queue read and write pointers SHALL wrap modulo QUEUE_DEPTH; the queue SHALL never overflow, which REQ-004 guarantees.
REQ-013 redirect_i SHALL have priority over all other events: the queue empties and count_o becomes 0 next cycle; the fetch PC becomes redirect_pc_i; any pop or push in that cycle is cancelled.
REQ-014 If a request is outstanding at redirect, or its handshake occurs in the redirect cycle, its response SHALL be discarded without a push.
REQ-015 dec_instr_o and dec_pc_o slots that are not valid SHALL be don't-care.

Reset
REQ-016 While rst_ni is low, asynchronously:
- fetch PC = RESET_PC;
- count_o = 0;
- dec_valid_o = 0;
- imem_req_valid_o = 0;
- the outstanding and discard flags are cleared.
REQ-017 The first request SHALL be issued in the first cycle after rst_ni deasserts.
REQ-018 A reset asserted while a request is outstanding SHALL cause that request's late response to be ignored.

Configuration
REQ-019 When FETCH_PERF_EN is defined:
- output perf_lines_o (32 bits) SHALL count accepted, non-discarded responses;
- output perf_stall_o (32 bits) SHALL count cycles in which count_o = 0 and redirect_i is low;
- both counters saturate at 2^32-1 and reset to 0.
REQ-020 When FETCH_PERF_EN is undefined, these ports and counters SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-021 Reset then stream, with FETCH_WIDTH=2, ready always high, and 1-cycle memory -> requests to 0x0, 0x8, 0x10; decode sees PC pairs (0,4), (8,C) with both valid bits set.
REQ-022 Hold dec_ready_i low -> request issue stops at count_o = 8 (depth 8); release -> 2 entries drain per cycle and no entry is lost.
REQ-023 Redirect to 0x104 while a request is outstanding -> the stale response is dropped; the next request is to 0x100; decode receives PC 0x104 alone with dec_valid_o = 01.
REQ-024 Redirect in the same cycle as a response push and a pop -> count_o = 0 next cycle; no stale PC is ever presented.
REQ-025 Fetch PC 0xFFFFFFF8 -> the next request address wraps to 0x0.
REQ-026 With FETCH_PERF_EN, 3 lines plus 4 empty cycles -> perf_lines_o = 3 and perf_stall_o = 4.
